// File: rtl/fire_pkg.sv
// Shared types and constants for the Fire-code polynomial divider.
package fire_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [8:0] FIRE_POLY_9 = 9'h011;  // x^9 + x^4 + 1, x^9 implicit

  localparam logic MODE_SYN = 1'b0;
  localparam logic MODE_ENC = 1'b1;
endpackage

// File: rtl/fire_lfsr_step.sv
// One single-bit division step; syndrome feeds the bit into the register,
// encode feeds it into the feedback tap (premultiplies by x^R).
module fire_lfsr_step import fire_pkg::*; #(
  parameter int              R    = 9,
  parameter logic [R-1:0]    POLY = FIRE_POLY_9
) (
  input  logic         mode,
  input  logic         b,
  input  logic [R-1:0] w_in,
  output logic [R-1:0] w_out
);
  logic f;

  always_comb begin
    f     = 1'b0;
    w_out = '0;
    if (mode == MODE_ENC) begin
      f     = b ^ w_in[R-1];
      w_out = {w_in[R-2:0], 1'b0} ^ (f ? POLY : '0);
    end else begin
      w_out = {w_in[R-2:0], b} ^ (w_in[R-1] ? POLY : '0);
    end
  end
endmodule

// File: rtl/fire_poly_div.sv
// Start/done polynomial divider: N-bit block, MSB first, S bits per clock,
// producing either d(x) mod g(x) or d(x)*x^R mod g(x).
module fire_poly_div import fire_pkg::*; #(
  parameter int           N    = 64,
  parameter int           R    = 9,
  parameter logic [R-1:0] POLY = FIRE_POLY_9,
  parameter int           S    = 1,
  parameter int           CW   = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          start,
  input  logic          mode,
  input  logic [N-1:0]  data_in,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [R-1:0]  rem_out,
  output logic          rem_zero,
  output logic [CW-1:0] count
);
  if (S < 1 || S > N || (N % S) != 0) begin : g_bad_s
    $error("fire_poly_div: S must divide N and lie in 1..N");
  end

  state_t          state, state_nxt;
  logic [N-1:0]    sreg;
  logic [R-1:0]    w;
  logic            mode_q;
  logic            last;
  logic [S:0][R-1:0] wc;

  // S chained steps consume sreg[N-1] .. sreg[N-S] in that order
  assign wc[0] = w;
  for (genvar k = 0; k < S; k++) begin : g_step
    fire_lfsr_step #(.R(R), .POLY(POLY)) u_step (
      .mode  (mode_q),
      .b     (sreg[N-1-k]),
      .w_in  (wc[k]),
      .w_out (wc[k+1])
    );
  end

  assign last  = (count >= CW'(N - S));
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !clear) state_nxt = RUN;
      RUN:     if (clear || last)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      w        <= '0;
      mode_q   <= MODE_SYN;
      count    <= '0;
      rem_out  <= '0;
      rem_zero <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && !clear) begin
          sreg   <= data_in;
          mode_q <= mode;
          w      <= '0;
          count  <= '0;
        end
      end else if (!clear) begin
        // a cleared job leaves count at its partial value and rem_out untouched
        w     <= wc[S];
        sreg  <= sreg << S;
        count <= last ? CW'(N) : count + CW'(S);
        if (last) begin
          rem_out  <= wc[S];
          rem_zero <= (wc[S] == '0);
          done     <= 1'b1;
        end
      end
    end
  end
endmodule
